// File: rtl/i2c_slave_engine.sv
// Byte-level I2C slave: filtered SDA/SCL, START/STOP detect, 7-bit address match, byte shifter.
// Define I2C_SLAVE_GENCALL_EN to also accept the general-call address (7'h00, write only).
module i2c_slave_engine #(
  parameter logic [6:0] SLAVE_ADDR   = 7'h0F,
  parameter int         FILTER_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_oen,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       rd_wr,
  output logic       busy
);

  localparam int CW = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
  localparam logic [CW-1:0] CMAX = CW'(FILTER_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  logic [1:0]    scl_sync;
  logic [1:0]    sda_sync;
  logic [CW-1:0] scl_cnt;
  logic [CW-1:0] sda_cnt;
  logic          scl_f;
  logic          sda_f;
  logic          scl_d;
  logic          sda_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

  // A line only flips after FILTER_DEPTH consecutive samples disagree with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_f   <= 1'b1;
      scl_cnt <= '0;
    end else if (scl_sync[1] == scl_f) begin
      scl_cnt <= '0;
    end else if (scl_cnt == CMAX) begin
      scl_f   <= scl_sync[1];
      scl_cnt <= '0;
    end else begin
      scl_cnt <= scl_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sda_f   <= 1'b1;
      sda_cnt <= '0;
    end else if (sda_sync[1] == sda_f) begin
      sda_cnt <= '0;
    end else if (sda_cnt == CMAX) begin
      sda_f   <= sda_sync[1];
      sda_cnt <= '0;
    end else begin
      sda_cnt <= sda_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

  function automatic logic addr_hit(input logic [7:0] b);
`ifdef I2C_SLAVE_GENCALL_EN
    return (b[7:1] == SLAVE_ADDR) ||
           ((b[7:1] == 7'h00) && !b[0]);
`else
    return b[7:1] == SLAVE_ADDR;
`endif
  endfunction

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [6:0] rx_sh, rx_sh_n;
  logic [6:0] tx_sh, tx_sh_n;
  logic       ph, ph_n;
  logic       first, first_n;
  logic       oen, oen_n;
  logic [7:0] rxd, rxd_n;
  logic       rxv_n;
  logic       rxf_n;
  logic       txr_n;
  logic       rw, rw_n;
  logic       bsy, bsy_n;
  logic       rxv;
  logic       rxf;
  logic       txr;
  logic [7:0] rx_byte;

  assign rx_byte = {rx_sh, sda_f};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      rx_sh <= '0;
      tx_sh <= '0;
      ph    <= 1'b0;
      first <= 1'b0;
      oen   <= 1'b1;
      rxd   <= '0;
      rxv   <= 1'b0;
      rxf   <= 1'b0;
      txr   <= 1'b0;
      rw    <= 1'b0;
      bsy   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rx_sh <= rx_sh_n;
      tx_sh <= tx_sh_n;
      ph    <= ph_n;
      first <= first_n;
      oen   <= oen_n;
      rxd   <= rxd_n;
      rxv   <= rxv_n;
      rxf   <= rxf_n;
      txr   <= txr_n;
      rw    <= rw_n;
      bsy   <= bsy_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rx_sh_n = rx_sh;
    tx_sh_n = tx_sh;
    ph_n    = ph;
    first_n = first;
    oen_n   = oen;
    rxd_n   = rxd;
    rxv_n   = 1'b0;
    rxf_n   = 1'b0;
    txr_n   = 1'b0;
    rw_n    = rw;
    bsy_n   = bsy;
    if (stop_det) begin
      state_n = IDLE;
      oen_n   = 1'b1;
      bsy_n   = 1'b0;
      ph_n    = 1'b0;
      cnt_n   = '0;
    end else if (start_det) begin
      state_n = ADDR;
      oen_n   = 1'b1;
      bsy_n   = 1'b0;
      ph_n    = 1'b0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
        end
        ADDR: begin
          if (scl_rise) begin
            rx_sh_n = rx_byte[6:0];
            cnt_n   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              ph_n = 1'b0;
              if (addr_hit(rx_byte)) begin
                rw_n    = rx_byte[0];
                bsy_n   = 1'b1;
                state_n = ADDR_ACK;
              end else begin
                state_n = WAIT_STOP;
              end
            end
          end
        end
        // First fall pulls SDA for ACK, second fall starts the data phase.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ph) begin
              oen_n = 1'b0;
              ph_n  = 1'b1;
            end else begin
              ph_n  = 1'b0;
              cnt_n = '0;
              if (rw) begin
                state_n = RD_DATA;
                tx_sh_n = tx_data[6:0];
                oen_n   = tx_data[7];
                txr_n   = 1'b1;
              end else begin
                state_n = WR_DATA;
                oen_n   = 1'b1;
                first_n = 1'b1;
              end
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            rx_sh_n = rx_byte[6:0];
            cnt_n   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              rxd_n   = rx_byte;
              rxv_n   = 1'b1;
              rxf_n   = first;
              first_n = 1'b0;
              ph_n    = 1'b0;
              state_n = WR_ACK;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (!ph) begin
              oen_n = 1'b0;
              ph_n  = 1'b1;
            end else begin
              oen_n   = 1'b1;
              ph_n    = 1'b0;
              cnt_n   = '0;
              state_n = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (cnt == 3'd7) begin
              oen_n   = 1'b1;
              cnt_n   = '0;
              ph_n    = 1'b0;
              state_n = RD_ACK;
            end else begin
              cnt_n   = cnt + 3'd1;
              oen_n   = tx_sh[6];
              tx_sh_n = {tx_sh[5:0], 1'b0};
            end
          end
        end
        // ph records a master ACK seen on the rising edge.
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_f) begin
              state_n = WAIT_STOP;
              bsy_n   = 1'b0;
            end else begin
              ph_n = 1'b1;
            end
          end else if (scl_fall && ph) begin
            ph_n    = 1'b0;
            cnt_n   = '0;
            tx_sh_n = tx_data[6:0];
            oen_n   = tx_data[7];
            txr_n   = 1'b1;
            state_n = RD_DATA;
          end
        end
        WAIT_STOP: begin
          oen_n = 1'b1;
        end
        default: begin
          state_n = IDLE;
          oen_n   = 1'b1;
        end
      endcase
    end
  end

  assign sda_o    = 1'b0;
  assign sda_oen  = oen;
  assign scl_o    = 1'b0;
  assign scl_oen  = 1'b1;
  assign rx_data  = rxd;
  assign rx_valid = rxv;
  assign rx_first = rxf;
  assign tx_req   = txr;
  assign rd_wr    = rw;
  assign busy     = bsy;

endmodule

// File: tb/tb_i2c_slave_engine.sv
// Bench for i2c_slave_engine: bit-banged I2C master, transaction-level model,
// scoreboard queues drained by a negedge monitor.
module tb_i2c_slave_engine;

  localparam int Q = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m_sda = 1'b1;
  logic       m_scl = 1'b1;
  logic       bus_sda;
  logic       sda_o;
  logic       sda_oen;
  logic       scl_o;
  logic       scl_oen;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       rd_wr;
  logic       busy;

  always #5 clk = ~clk;

  assign bus_sda = m_sda & (sda_oen ? 1'b1 : sda_o);

  logic [7:0] tx_mem [256];
  int tx_ptr = 0;
  int tx_cnt = 0;
  int oen_low_cnt = 0;
  int mp = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic prev_oen = 1'b1;
  logic [7:0] wdat [4];

  assign tx_data = tx_mem[tx_ptr[7:0]];

  typedef struct {
    logic [7:0] d;
    logic       f;
  } rx_t;

  rx_t        exp_rx [$];
  logic [7:0] exp_rd [$];
  logic [7:0] got_rd [$];
  rx_t        mon_e;

  i2c_slave_engine dut (
    .clk      (clk),
    .reset    (reset),
    .sda_i    (bus_sda),
    .sda_o    (sda_o),
    .sda_oen  (sda_oen),
    .scl_i    (m_scl),
    .scl_o    (scl_o),
    .scl_oen  (scl_oen),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_first (rx_first),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rd_wr    (rd_wr),
    .busy     (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (!sda_oen) oen_low_cnt++;
      if (sda_oen != prev_oen) chk("drive_while_scl_low", m_scl, 0);
      if (rx_valid) begin
        chk("rxv_txr_exclusive", tx_req, 0);
        if (exp_rx.size() == 0) begin
          chk("unexpected_rx_valid", 1, 0);
        end else begin
          mon_e = exp_rx.pop_front();
          chk("rx_data", rx_data, mon_e.d);
          chk("rx_first", rx_first, mon_e.f);
        end
      end
      if (tx_req) begin
        tx_cnt++;
        tx_ptr++;
      end
      while (exp_rd.size() > 0 && got_rd.size() > 0)
        chk("read_byte", got_rd.pop_front(), exp_rd.pop_front());
    end
    prev_oen = sda_oen;
  end

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bit_io(input logic b, output logic r);
    wq(); m_sda = b;
    wq(); m_scl = 1'b1;
    wq(); r = bus_sda;
    wq(); m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    wq(); m_sda = 1'b1;
    wq(); m_scl = 1'b1;
    wq(); m_sda = 1'b0;
    wq(); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wq(); m_sda = 1'b0;
    wq(); m_scl = 1'b1;
    wq(); m_sda = 1'b1;
    wq(); wq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic nack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(d[i], r);
    bit_io(1'b1, nack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      bit_io(1'b1, r);
      d = {d[6:0], r};
    end
    bit_io(mack, r);
  endtask

  task automatic do_txn(input logic [6:0] a, input logic rw,
                        input int n, input logic stop_end);
    logic m, nk;
    logic [7:0] d;
    int oen0, tx0, exp_tx;
    m = (a == 7'h0F);
`ifdef I2C_SLAVE_GENCALL_EN
    m = m || (a == 7'h00 && !rw);
`endif
    oen0 = oen_low_cnt;
    tx0 = tx_cnt;
    exp_tx = 0;
    i2c_start();
    write_byte({a, rw}, nk);
    chk("addr_ack", nk, !m);
    chk("busy_after_addr", busy, m);
    if (m) chk("rd_wr", rd_wr, rw);
    for (int i = 0; i < n; i++) begin
      if (!rw) begin
        d = wdat[i];
        if (m) exp_rx.push_back('{d: d, f: (i == 0)});
        write_byte(d, nk);
        chk("data_ack", nk, !m);
      end else begin
        if (m) begin
          exp_rd.push_back(tx_mem[mp[7:0]]);
          mp++;
          exp_tx++;
        end
        read_byte(i == n - 1, d);
        if (m) got_rd.push_back(d);
        else chk("idle_read", d, 8'hFF);
      end
    end
    if (rw && m) chk("busy_after_nack", busy, 0);
    if (stop_end) begin
      i2c_stop();
      chk("busy_after_stop", busy, 0);
      repeat (4) @(negedge clk);
      chk("rx_drained", exp_rx.size(), 0);
    end
    chk("tx_req_count", tx_cnt - tx0, exp_tx);
    if (!m) chk("no_drive_on_mismatch", oen_low_cnt - oen0, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] a;
    logic nk, r;
    logic [7:0] ab;
    int oen0;
    for (int i = 0; i < 256; i++) tx_mem[i] = 8'($urandom);
    repeat (5) @(negedge clk);
    chk("reset_outputs",
        {sda_oen, scl_oen, rx_valid, rx_first, tx_req, rd_wr, busy, rx_data},
        {1'b1, 1'b1, 13'h0});
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    wdat[0] = 8'hA5; wdat[1] = 8'h3C;
    do_txn(7'h0F, 1'b0, 2, 1'b1);

    tx_mem[mp[7:0]] = 8'h5A;
    tx_mem[8'(mp + 1)] = 8'hC3;
    do_txn(7'h0F, 1'b1, 2, 1'b1);

    wdat[0] = 8'h55;
    do_txn(7'h10, 1'b0, 1, 1'b1);

    wdat[0] = 8'h01;
    do_txn(7'h0F, 1'b0, 1, 1'b0);
    do_txn(7'h0F, 1'b1, 1, 1'b1);

    // Short SDA dip with SCL high must not open a transaction.
    oen0 = oen_low_cnt;
    @(posedge clk); #1 m_sda = 1'b0;
    repeat (2) @(posedge clk);
    #1 m_sda = 1'b1;
    repeat (20) @(posedge clk);
    #1 m_scl = 1'b0;
    write_byte(8'h1E, nk);
    chk("glitch_no_ack", nk, 1);
    chk("glitch_busy", busy, 0);
    chk("glitch_no_drive", oen_low_cnt - oen0, 0);
    i2c_stop();

    i2c_start();
    ab = 8'h1E;
    for (int i = 7; i >= 0; i--) bit_io(ab[i], r);
    wq(); m_sda = 1'b1;
    wq();
    @(negedge clk);
    chk("ack_driven", sda_oen, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_ack",
        {sda_oen, rx_valid, rx_first, tx_req, rd_wr, busy, rx_data},
        {1'b1, 13'h0});
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    wdat[0] = 8'($urandom); wdat[1] = 8'($urandom);
    do_txn(7'h0F, 1'b0, 2, 1'b1);

    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(1, 0) == 1) begin
        a = 7'h0F;
      end else begin
        a = 7'($urandom);
        if (a == 7'h0F) a = 7'h3C;
      end
      for (int i = 0; i < 4; i++) wdat[i] = 8'($urandom);
      do_txn(a, 1'($urandom_range(1, 0)), $urandom_range(3, 1), 1'b1);
    end

    repeat (50) @(negedge clk);
    chk("rd_drained", exp_rd.size() + got_rd.size(), 0);
    chk("rx_drained_final", exp_rx.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
